// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// State encoding and requester port identifiers used by the arbiter and its selector.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RD_WAIT,
        ARB_RESP
    } arb_state_t;

    // Port 0 is the Control_Unit LOAD/STORE path, port 1 the program/debug loader.
    localparam logic PORT_CU  = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins around the arbiter.
// slave = arbiter side; master = requesters plus the memory that answers D_RDATA.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);

    logic              REQ0;
    logic              WE0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] WDATA0;
    logic              GNT0;
    logic              RVALID0;

    logic              REQ1;
    logic              WE1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA1;
    logic              GNT1;
    logic              RVALID1;

    logic [DATA_W-1:0] RDATA;
    logic [ADDR_W-1:0] D_ADDR;
    logic              D_WR;
    logic [DATA_W-1:0] D_WDATA;
    logic [DATA_W-1:0] D_RDATA;
    logic              BUSY;

    modport slave (
        input  REQ0, WE0, ADDR0, WDATA0,
        input  REQ1, WE1, ADDR1, WDATA1,
        input  D_RDATA,
        output GNT0, RVALID0, GNT1, RVALID1,
        output RDATA, D_ADDR, D_WR, D_WDATA, BUSY
    );

    modport master (
        output REQ0, WE0, ADDR0, WDATA0,
        output REQ1, WE1, ADDR1, WDATA1,
        output D_RDATA,
        input  GNT0, RVALID0, GNT1, RVALID1,
        input  RDATA, D_ADDR, D_WR, D_WDATA, BUSY
    );

endinterface

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin selector: combinational winner, registered priority pointer.
// The pointer flips to the other port on every accepted grant.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic winner,
    output logic any_req
);

    logic rr_ptr;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        any_req = req0 | req1;
        winner  = PORT_CU;
        if (req0 && req1) begin
            winner = rr_ptr;
        end else if (req1) begin
            winner = PORT_LDR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rr_ptr <= PORT_CU;
        end else if (advance) begin
            rr_ptr <= ~winner;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the Control_Unit and the loader.
// One transaction in flight; reads return on a registered RDATA after RD_LAT cycles.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input logic                Clock,
    input logic                Reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              winner;
    logic              any_req;
    logic              advance;
    logic              rd_last;
    logic              lat_we;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  rd_cnt;

    // Requests are only looked at while idle; anything raised mid-transaction waits.
    assign advance = (state == ARB_IDLE) && any_req;
    assign rd_last = (state == ARB_RD_WAIT) && (rd_cnt == '0);

    rr_arb2 u_rr_arb2 (
        .Clock   (Clock),
        .Reset   (Reset),
        .req0    (bus.REQ0),
        .req1    (bus.REQ1),
        .advance (advance),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:    if (any_req) state_nxt = ARB_ACCESS;
            ARB_ACCESS:  state_nxt = lat_we ? ARB_IDLE : ARB_RD_WAIT;
            ARB_RD_WAIT: if (rd_cnt == '0) state_nxt = ARB_RESP;
            ARB_RESP:    state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    // Winner's command is frozen at the grant edge; D_ADDR/D_WDATA hold it until the next grant.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            lat_we   <= 1'b0;
            lat_port <= PORT_CU;
            lat_addr <= '0;
            lat_data <= '0;
        end else if (advance) begin
            lat_port <= winner;
            lat_we   <= (winner == PORT_LDR) ? bus.WE1    : bus.WE0;
            lat_addr <= (winner == PORT_LDR) ? bus.ADDR1  : bus.ADDR0;
            lat_data <= (winner == PORT_LDR) ? bus.WDATA1 : bus.WDATA0;
        end
    end

    // RD_WAIT lasts RD_LAT cycles; the count is reloaded at every ACCESS.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_cnt <= '0;
        end else if (state == ARB_ACCESS) begin
            rd_cnt <= CNT_W'(RD_LAT - 1);
        end else if ((state == ARB_RD_WAIT) && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (rd_last) begin
            rdata_q <= bus.D_RDATA;
        end
    end

    // Decoded straight from state so a reset pulls them low without waiting for a clock.
    assign bus.GNT0    = (state == ARB_ACCESS) && (lat_port == PORT_CU);
    assign bus.GNT1    = (state == ARB_ACCESS) && (lat_port == PORT_LDR);
    assign bus.RVALID0 = (state == ARB_RESP)   && (lat_port == PORT_CU);
    assign bus.RVALID1 = (state == ARB_RESP)   && (lat_port == PORT_LDR);
    assign bus.D_WR    = (state == ARB_ACCESS) && lat_we;
    assign bus.D_ADDR  = lat_addr;
    assign bus.D_WDATA = lat_data;
    assign bus.RDATA   = rdata_q;
    assign bus.BUSY    = (state != ARB_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (RD_LAT 1, 3, 4) each with a memory model,
// checked against a transaction-level reference (shadow memory + round-robin rule).
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  req0, we0, req1, we1;
    logic [7:0]  addr0 [3];
    logic [7:0]  addr1 [3];
    logic [15:0] wdata0 [3];
    logic [15:0] wdata1 [3];

    logic [2:0]  gnt0, gnt1, rv0, rv1, dwr, busy;
    logic [7:0]  daddr [3];
    logic [15:0] dwdata [3];
    logic [15:0] rdata [3];

    logic [15:0] ref_mem [3][256];
    int          last_port [3];
    int          n_cmp;
    int          n_bad;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        dmem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

        dmem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(LAT)) dut (
            .Clock (clk),
            .Reset (rst[g]),
            .bus   (bus)
        );

        assign bus.REQ0   = req0[g];
        assign bus.WE0    = we0[g];
        assign bus.ADDR0  = addr0[g];
        assign bus.WDATA0 = wdata0[g];
        assign bus.REQ1   = req1[g];
        assign bus.WE1    = we1[g];
        assign bus.ADDR1  = addr1[g];
        assign bus.WDATA1 = wdata1[g];

        assign gnt0[g]   = bus.GNT0;
        assign gnt1[g]   = bus.GNT1;
        assign rv0[g]    = bus.RVALID0;
        assign rv1[g]    = bus.RVALID1;
        assign dwr[g]    = bus.D_WR;
        assign busy[g]   = bus.BUSY;
        assign daddr[g]  = bus.D_ADDR;
        assign dwdata[g] = bus.D_WDATA;
        assign rdata[g]  = bus.RDATA;

        // Memory with LAT-cycle read pipeline: data for the address of cycle t appears in t+LAT.
        logic [15:0] mem [256];
        logic [15:0] pipe [LAT];
        always @(posedge clk) begin
            if (bus.D_WR) mem[bus.D_ADDR] <= bus.D_WDATA;
            pipe[0] <= mem[bus.D_ADDR];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.D_RDATA = pipe[LAT-1];
    end

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 1 : ((inst == 1) ? 3 : 4);
    endfunction

    function automatic logic f_gnt(input int inst, input bit port);
        return port ? gnt1[inst] : gnt0[inst];
    endfunction

    function automatic logic f_rv(input int inst, input bit port);
        return port ? rv1[inst] : rv0[inst];
    endfunction

    task automatic set_req(input int inst, input bit port, input bit we,
                           input logic [7:0] a, input logic [15:0] d);
        if (!port) begin
            req0[inst] = 1'b1; we0[inst] = we; addr0[inst] = a; wdata0[inst] = d;
        end else begin
            req1[inst] = 1'b1; we1[inst] = we; addr1[inst] = a; wdata1[inst] = d;
        end
    endtask

    task automatic drop_req(input int inst, input bit port);
        if (!port) req0[inst] = 1'b0;
        else       req1[inst] = 1'b0;
    endtask

    task automatic do_reset(input int inst);
        req0[inst] = 1'b0;
        req1[inst] = 1'b0;
        rst[inst]  = 1'b1;
        @(posedge clk); #1;
        rst[inst]  = 1'b0;
        last_port[inst] = 1;
    endtask

    task automatic step_idle(input int inst);
        @(posedge clk); #1;
        n_cmp++;
        if (busy[inst] !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_txn inst=%0d BUSY=%b expected 0", inst, busy[inst]);
        end
    endtask

    // Request must already be driven; expects GNT after exp_wait cycles, then follows the
    // transaction to its last busy cycle (ACCESS for writes, RESP for reads).
    task automatic serve(input int inst, input bit port, input bit we,
                         input logic [7:0] a, input logic [15:0] d, input int exp_wait);
        int waited;
        int lat;
        bit hold_bad;
        logic [15:0] exp_rd;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!f_gnt(inst, port) && waited < 30);
        n_cmp++;
        if (waited != exp_wait || f_gnt(inst, port) !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_latency inst=%0d port=%0d waited=%0d expected=%0d",
                     inst, port, waited, exp_wait);
            drop_req(inst, port);
            return;
        end
        n_cmp++;
        if (f_gnt(inst, !port) !== 1'b0 || dwr[inst] !== we || daddr[inst] !== a) begin
            n_bad++;
            $display("FAIL access_cycle inst=%0d port=%0d other_gnt=%b D_WR=%b D_ADDR=%h expected 0/%b/%h",
                     inst, port, f_gnt(inst, !port), dwr[inst], daddr[inst], we, a);
        end
        last_port[inst] = int'(port);
        drop_req(inst, port);
        if (we) begin
            n_cmp++;
            if (dwdata[inst] !== d) begin
                n_bad++;
                $display("FAIL write_data inst=%0d D_WDATA=%h expected %h", inst, dwdata[inst], d);
            end
            ref_mem[inst][a] = d;
            return;
        end
        exp_rd = ref_mem[inst][a];
        lat = 0;
        hold_bad = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!f_rv(inst, port) && (daddr[inst] !== a || dwr[inst] !== 1'b0)) hold_bad = 1'b1;
        end while (!f_rv(inst, port) && lat < 30);
        n_cmp++;
        if (lat != lat_of(inst) + 1 || f_rv(inst, port) !== 1'b1) begin
            n_bad++;
            $display("FAIL rvalid_latency inst=%0d port=%0d cycles=%0d expected=%0d",
                     inst, port, lat, lat_of(inst) + 1);
        end
        n_cmp++;
        if (rdata[inst] !== exp_rd || f_rv(inst, !port) !== 1'b0) begin
            n_bad++;
            $display("FAIL read_data inst=%0d port=%0d RDATA=%h other_rvalid=%b expected %h/0",
                     inst, port, rdata[inst], f_rv(inst, !port), exp_rd);
        end
        n_cmp++;
        if (hold_bad) begin
            n_bad++;
            $display("FAIL rd_wait_hold inst=%0d D_ADDR not held at %h or D_WR high", inst, a);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({busy[i], gnt0[i], gnt1[i], rv0[i], rv1[i], dwr[i]} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_ctrl inst=%0d bits=%b expected 000000", i,
                         {busy[i], gnt0[i], gnt1[i], rv0[i], rv1[i], dwr[i]});
            end
            n_cmp++;
            if (rdata[i] !== 16'h0 || daddr[i] !== 8'h0 || dwdata[i] !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_data inst=%0d RDATA=%h D_ADDR=%h D_WDATA=%h expected 0",
                         i, rdata[i], daddr[i], dwdata[i]);
            end
        end
        rst = 3'b000;
        for (int i = 0; i < 3; i++) last_port[i] = 1;
        step_idle(0);
    endtask

    task automatic test_write();
        set_req(0, 0, 1'b1, 8'h10, 16'hBEEF);
        serve(0, 0, 1'b1, 8'h10, 16'hBEEF, 1);
        @(posedge clk); #1;
        n_cmp++;
        if (dwr[0] !== 1'b0 || busy[0] !== 1'b0 || daddr[0] !== 8'h10 || dwdata[0] !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL write_after D_WR=%b BUSY=%b D_ADDR=%h D_WDATA=%h expected 0/0/10/beef",
                     dwr[0], busy[0], daddr[0], dwdata[0]);
        end
    endtask

    task automatic test_read_back();
        set_req(0, 0, 1'b0, 8'h10, 16'h0);
        serve(0, 0, 1'b0, 8'h10, 16'h0, 1);
        @(posedge clk); #1;
        n_cmp++;
        if (rv0[0] !== 1'b0 || rdata[0] !== 16'hBEEF || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL read_after RVALID0=%b RDATA=%h BUSY=%b expected 0/beef/0",
                     rv0[0], rdata[0], busy[0]);
        end
    endtask

    task automatic test_contention();
        int grants;
        int cyc;
        bit dbl;
        do_reset(0);
        set_req(0, 0, 1'b1, 8'h20, 16'hA5A5);
        set_req(0, 1, 1'b1, 8'h21, 16'h5A5A);
        grants = 0;
        cyc = 0;
        dbl = 1'b0;
        while (grants < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (gnt0[0] && gnt1[0]) begin
                dbl = 1'b1;
            end else if (gnt0[0] || gnt1[0]) begin
                n_cmp++;
                if (int'(gnt1[0]) != grants % 2) begin
                    n_bad++;
                    $display("FAIL contention_order grant#%0d got port %0d expected %0d",
                             grants, gnt1[0], grants % 2);
                end
                grants++;
            end
        end
        drop_req(0, 0);
        drop_req(0, 1);
        last_port[0] = 1;
        ref_mem[0][8'h20] = 16'hA5A5;
        ref_mem[0][8'h21] = 16'h5A5A;
        n_cmp++;
        if (dbl || grants != 4) begin
            n_bad++;
            $display("FAIL contention_grants double=%0d count=%0d expected 0/4", dbl, grants);
        end
        step_idle(0);
    endtask

    task automatic test_single_rr1();
        // One port-0 grant leaves the pointer favouring port 1; a lone REQ0 must not stall.
        set_req(0, 0, 1'b1, 8'h22, 16'h0F0F);
        serve(0, 0, 1'b1, 8'h22, 16'h0F0F, 1);
        step_idle(0);
        set_req(0, 0, 1'b0, 8'h21, 16'h0);
        serve(0, 0, 1'b0, 8'h21, 16'h0, 1);
        step_idle(0);
    endtask

    task automatic test_reset_mid_read();
        int seen;
        set_req(1, 1, 1'b1, 8'h40, 16'hC0DE);
        serve(1, 1, 1'b1, 8'h40, 16'hC0DE, 1);
        step_idle(1);
        set_req(1, 0, 1'b0, 8'h40, 16'h0);
        @(posedge clk); #1;
        n_cmp++;
        if (gnt0[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrd_grant GNT0=%b expected 1", gnt0[1]);
        end
        drop_req(1, 0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst[1] = 1'b1;
        #1;
        n_cmp++;
        if (busy[1] !== 1'b0 || rv0[1] !== 1'b0 || dwr[1] !== 1'b0 || rdata[1] !== 16'h0) begin
            n_bad++;
            $display("FAIL midrd_async BUSY=%b RVALID0=%b D_WR=%b RDATA=%h expected 0/0/0/0",
                     busy[1], rv0[1], dwr[1], rdata[1]);
        end
        @(posedge clk); #3;
        rst[1] = 1'b0;
        last_port[1] = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rv0[1] || rv1[1] || busy[1]) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midrd_dropped activity_cycles=%0d expected 0", seen);
        end
        set_req(1, 1, 1'b0, 8'h40, 16'h0);
        serve(1, 1, 1'b0, 8'h40, 16'h0, 1);
        step_idle(1);
    endtask

    task automatic test_lat4();
        set_req(2, 1, 1'b1, 8'hFF, 16'h1234);
        serve(2, 1, 1'b1, 8'hFF, 16'h1234, 1);
        step_idle(2);
        set_req(2, 0, 1'b0, 8'hFF, 16'h0);
        serve(2, 0, 1'b0, 8'hFF, 16'h0, 1);
        step_idle(2);
    endtask

    task automatic test_random(input int inst);
        bit          w, l, we_w, we_l, p, we;
        logic [7:0]  a_w, a_l, a;
        logic [15:0] d_w, d_l, d;
        for (int i = 0; i < 8; i++) begin
            p = bit'(i % 2);
            d = 16'($urandom);
            set_req(inst, p, 1'b1, 8'(i), d);
            serve(inst, p, 1'b1, 8'(i), d, 1);
            step_idle(inst);
        end
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 2) == 2) begin
                // Favoured port is the opposite of the one granted last.
                w    = (last_port[inst] == 1) ? 1'b0 : 1'b1;
                l    = !w;
                we_w = bit'($urandom_range(0, 1));
                we_l = bit'($urandom_range(0, 1));
                a_w  = 8'($urandom_range(0, 7));
                a_l  = 8'($urandom_range(0, 7));
                d_w  = 16'($urandom);
                d_l  = 16'($urandom);
                set_req(inst, w, we_w, a_w, d_w);
                set_req(inst, l, we_l, a_l, d_l);
                serve(inst, w, we_w, a_w, d_w, 1);
                serve(inst, l, we_l, a_l, d_l, 2);
            end else begin
                p  = bit'($urandom_range(0, 1));
                we = bit'($urandom_range(0, 1));
                a  = 8'($urandom_range(0, 7));
                d  = 16'($urandom);
                set_req(inst, p, we, a, d);
                serve(inst, p, we, a, d, 1);
            end
            step_idle(inst);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 3'b111;
        req0  = '0; we0 = '0; req1 = '0; we1 = '0;
        for (int i = 0; i < 3; i++) begin
            addr0[i] = 8'h0; addr1[i] = 8'h0; wdata0[i] = 16'h0; wdata1[i] = 16'h0;
            last_port[i] = 1;
            for (int j = 0; j < 256; j++) ref_mem[i][j] = 16'h0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        test_write();
        test_read_back();
        test_contention();
        test_single_rr1();
        test_reset_mid_read();
        test_lat4();
        test_random(0);
        test_random(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
